// File: rtl/mul4_share_arb_pkg.sv
// Shared definitions for the mul4_share_arb block: operand/product widths,
// response counter width and the product-register state encoding.
package mul4_share_arb_pkg;
  localparam int OPND_W = 4;
  localparam int PROD_W = 8;
  localparam int CNT_W  = 16;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;
endpackage

// File: rtl/MulWTKS.sv
// MulWTKS: combinational 4x4 unsigned multiplier.
// Ports:
//   A  in  4  multiplicand
//   B  in  4  multiplier
//   S  out 8  full-width product A*B
module MulWTKS (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [7:0] S
);
  // Sum of the four shifted partial products.
  logic [7:0] pp0, pp1, pp2, pp3;

  assign pp0 = B[0] ? {4'b0000, A}       : 8'd0;
  assign pp1 = B[1] ? {3'b000, A, 1'b0}  : 8'd0;
  assign pp2 = B[2] ? {2'b00, A, 2'b00}  : 8'd0;
  assign pp3 = B[3] ? {1'b0, A, 3'b000}  : 8'd0;

  assign S = (pp0 + pp1) + (pp2 + pp3);
endmodule

// File: rtl/mul4_share_arb_rr_arbiter.sv
// mul4_share_arb_rr_arbiter: rotating-priority arbiter.
// The first set bit of req_i found when searching upward from ptr_i+1
// (modulo N_REQ) wins. Tying ptr_i to N_REQ-1 gives fixed lowest-index priority.
// Ports:
//   req_i  in  N_REQ  request vector
//   ptr_i  in  ID_W   index of the last winner
//   gnt_o  out N_REQ  one-hot grant, zero when no request
//   idx_o  out ID_W   index of the granted requester (0 when none)
module mul4_share_arb_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  idx_o
);
  logic            found;
  logic [ID_W-1:0] pos;
  int              pos_int;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    found   = 1'b0;
    pos     = '0;
    pos_int = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      pos_int = (int'(ptr_i) + k) % N_REQ;
      pos     = ID_W'(pos_int);
      if (!found && req_i[pos]) begin
        found      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = pos;
      end
    end
  end
endmodule

// File: rtl/mul4_share_arb.sv
// mul4_share_arb: shares one MulWTKS 4x4 multiplier among N_REQ requesters.
// One requester is granted per cycle while the single product register is
// free (or draining this cycle); the product and winner ID are held until
// the consumer accepts them.
// Optional feature: define MUL4_SHARE_ARB_RR_EN for round-robin arbitration;
// otherwise the lowest valid index always wins.
// Ports:
//   clk        in  1           rising-edge clock
//   rst_n      in  1           asynchronous active-low reset
//   req_valid  in  N_REQ       per-requester operand valid
//   req_a      in  4*N_REQ     operand A, requester i at [4i+3:4i]
//   req_b      in  4*N_REQ     operand B, same packing
//   req_ready  out N_REQ       one-hot or zero grant
//   rsp_valid  out 1           product register occupied
//   rsp_ready  in  1           consumer accepts the product
//   rsp_s      out 8           product A*B
//   rsp_id     out ID_W        requester that produced rsp_s
//   op_count   out 16          completed responses, wraps
//   busy       out 1           rsp_valid or any request pending
module mul4_share_arb
  import mul4_share_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [OPND_W*N_REQ-1:0]   req_a,
  input  logic [OPND_W*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [PROD_W-1:0]         rsp_s,
  output logic [ID_W-1:0]           rsp_id,
  output logic [CNT_W-1:0]          op_count,
  output logic                      busy
);
  state_e            state_q;
  logic [PROD_W-1:0] rsp_s_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic [CNT_W-1:0]  op_count_q;

  logic              slot_free;
  logic [N_REQ-1:0]  arb_req;
  logic [N_REQ-1:0]  gnt;
  logic [ID_W-1:0]   win_idx;
  logic [ID_W-1:0]   arb_ptr;
  logic              xfer;

  logic [OPND_W-1:0] a_arr [N_REQ];
  logic [OPND_W-1:0] b_arr [N_REQ];
  logic [OPND_W-1:0] mul_a, mul_b;
  logic [PROD_W-1:0] mul_s;

  // The register can take a new product when empty, or when its current
  // content is being drained on this same edge.
  assign slot_free = (state_q == ST_EMPTY) | rsp_ready;
  assign arb_req   = req_valid & {N_REQ{slot_free}};
  assign xfer      = |gnt;

  mul4_share_arb_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req_i (arb_req),
    .ptr_i (arb_ptr),
    .gnt_o (gnt),
    .idx_o (win_idx)
  );

`ifdef MUL4_SHARE_ARB_RR_EN
  logic [ID_W-1:0] rr_ptr_q;

  // Reset value N_REQ-1 makes requester 0 the first winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= ID_W'(N_REQ - 1);
    end else if (xfer) begin
      rr_ptr_q <= win_idx;
    end
  end

  assign arb_ptr = rr_ptr_q;
`else
  assign arb_ptr = ID_W'(N_REQ - 1);
`endif

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[g*OPND_W +: OPND_W];
    assign b_arr[g] = req_b[g*OPND_W +: OPND_W];
  end

  // Multiplier inputs sit at zero unless a transfer is in progress.
  assign mul_a = xfer ? a_arr[win_idx] : '0;
  assign mul_b = xfer ? b_arr[win_idx] : '0;

  MulWTKS u_mul (
    .A (mul_a),
    .B (mul_b),
    .S (mul_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      rsp_s_q    <= '0;
      rsp_id_q   <= '0;
      op_count_q <= '0;
    end else begin
      if ((state_q == ST_FULL) && rsp_ready) begin
        op_count_q <= op_count_q + 16'd1;
      end
      if (xfer) begin
        rsp_s_q  <= mul_s;
        rsp_id_q <= win_idx;
      end
      case (state_q)
        ST_EMPTY: if (xfer) state_q <= ST_FULL;
        ST_FULL:  if (rsp_ready && !xfer) state_q <= ST_EMPTY;
        default:  state_q <= ST_EMPTY;
      endcase
    end
  end

  assign req_ready = gnt;
  assign rsp_valid = (state_q == ST_FULL);
  assign rsp_s     = rsp_s_q;
  assign rsp_id    = rsp_id_q;
  assign op_count  = op_count_q;
  assign busy      = rsp_valid | (|req_valid);
endmodule

// File: tb/tb_mul4_share_arb.sv
module tb_mul4_share_arb;
  localparam int N = 4;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [4*N-1:0] req_a;
  logic [4*N-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [7:0]     rsp_s;
  logic [1:0]     rsp_id;
  logic [15:0]    op_count;
  logic           busy;

  typedef struct packed {
    logic [7:0] s;
    logic [1:0] id;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;

  mul4_share_arb #(.N_REQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_s     (rsp_s),
    .rsp_id    (rsp_id),
    .op_count  (op_count),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted response is compared against the oldest entry.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got s=%0d id=%0d expected none", rsp_s, rsp_id);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_s", 32'(rsp_s), 32'(e.s));
        check("rsp_id", 32'(rsp_id), 32'(e.id));
      end
    end
  end

  task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
    req_a[4*i +: 4] = a;
    req_b[4*i +: 4] = b;
  endtask

  // Entered just after a rising edge. Drives one cycle, checks the grant,
  // and records the product each expected winner should produce.
  task automatic step(input logic [N-1:0] vld, input logic rdy,
                      input logic [N-1:0] exp_gnt, input string nm);
    exp_t e;
    req_valid = vld;
    rsp_ready = rdy;
    @(negedge clk);
    check(nm, 32'(req_ready), 32'(exp_gnt));
    for (int i = 0; i < N; i++) begin
      if (exp_gnt[i]) begin
        e.s  = {4'b0000, req_a[4*i +: 4]} * {4'b0000, req_b[4*i +: 4]};
        e.id = 2'(i);
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] held_s;
    logic [1:0] held_id;
    checks = 0;
    errors = 0;
    req_a = '0;
    req_b = '0;

    // Reset and idle
    do_reset();
    @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    check("rst_rsp_s", 32'(rsp_s), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    // Single op on requester 2: 15*15 = 225
    set_op(2, 4'd15, 4'd15);
    step(4'b0100, 1'b1, 4'b0100, "single_gnt");
    req_valid = '0;
    check("single_vld", 32'(rsp_valid), 32'd1);
    check("single_s", 32'(rsp_s), 32'd225);
    check("single_id", 32'(rsp_id), 32'd2);
    step(4'b0000, 1'b1, 4'b0000, "single_drain");
    check("single_empty", 32'(rsp_valid), 32'd0);
    check("single_count", 32'(op_count), 32'd1);

    // Fairness with all four requesters valid
    do_reset();
    set_op(0, 4'd1, 4'd5);
    set_op(1, 4'd2, 4'd6);
    set_op(2, 4'd3, 4'd7);
    set_op(3, 4'd4, 4'd8);
`ifdef MUL4_SHARE_ARB_RR_EN
    step(4'b1111, 1'b1, 4'b0001, "fair_g0");
    step(4'b1111, 1'b1, 4'b0010, "fair_g1");
    step(4'b1111, 1'b1, 4'b0100, "fair_g2");
    step(4'b1111, 1'b1, 4'b1000, "fair_g3");
    step(4'b1111, 1'b1, 4'b0001, "fair_g4");
`else
    for (int i = 0; i < 5; i++) step(4'b1111, 1'b1, 4'b0001, "fixed_g0");
`endif
    step(4'b0000, 1'b1, 4'b0000, "fair_drain");

    // Backpressure with requesters 0 and 1 pending
`ifdef MUL4_SHARE_ARB_RR_EN
    step(4'b0011, 1'b0, 4'b0010, "bp_first");
    held_s  = 8'd12;
    held_id = 2'd1;
`else
    step(4'b0011, 1'b0, 4'b0001, "bp_first");
    held_s  = 8'd5;
    held_id = 2'd0;
`endif
    for (int i = 0; i < 5; i++) begin
      step(4'b0011, 1'b0, 4'b0000, "bp_hold_gnt");
      check("bp_hold_s", 32'(rsp_s), 32'(held_s));
      check("bp_hold_id", 32'(rsp_id), 32'(held_id));
      check("bp_hold_vld", 32'(rsp_valid), 32'd1);
    end
    step(4'b0011, 1'b1, 4'b0001, "bp_release_gnt");
    check("bp_no_bubble", 32'(rsp_valid), 32'd1);
    check("bp_new_s", 32'(rsp_s), 32'd5);
    step(4'b0000, 1'b1, 4'b0000, "bp_drain");

    // Exhaustive operand sweep through each requester
    for (int id = 0; id < N; id++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          set_op(id, 4'(a), 4'(b));
          step(N'(1 << id), 1'b1, N'(1 << id), "exh_gnt");
        end
      end
    end
    step(4'b0000, 1'b1, 4'b0000, "exh_drain");
    check("exh_sb_empty", 32'(sb.size()), 32'd0);

    // Counter wrap after 65536 completions
    do_reset();
    set_op(0, 4'd1, 4'd1);
    for (int i = 0; i < 65536; i++) step(4'b0001, 1'b1, 4'b0001, "wrap_gnt");
    req_valid = '0;
    @(negedge clk);
    check("wrap_ffff", 32'(op_count), 32'h0000FFFF);
    @(posedge clk);
    #1;
    check("wrap_zero", 32'(op_count), 32'd0);
    check("wrap_empty", 32'(rsp_valid), 32'd0);

    // Reset while holding a product
    set_op(1, 4'd9, 4'd9);
    step(4'b0010, 1'b0, 4'b0010, "rstfull_gnt");
    check("rstfull_vld_before", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("rstfull_vld", 32'(rsp_valid), 32'd0);
    check("rstfull_count", 32'(op_count), 32'd0);
    check("rstfull_s", 32'(rsp_s), 32'd0);
    req_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("rstfull_resume_vld", 32'(rsp_valid), 32'd0);
    check("rstfull_resume_gnt", 32'(req_ready), 32'd0);
    repeat (2) @(posedge clk);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
